// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter.
//   state_e : sequencer states (IDLE, ISSUE, WAIT)
//   owner_e : requester identity (OWN_IF = fetch path, OWN_D = data path)
//   CNT_W   : width of the read-latency down-counter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam int CNT_W = 3;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin selector (purely combinational).
//   req_i        : request vector, bit 0 = fetch, bit 1 = data
//   last_owner_i : requester that received the previous grant
//   enable_i     : arbitration allowed this cycle
//   gnt_o        : one-hot grant, all zero when disabled or idle
//   winner_o     : selected requester (meaningful only when gnt_o != 0)
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  owner_e     last_owner_i,
    input  logic       enable_i,
    output logic [1:0] gnt_o,
    output owner_e     winner_o
);

    always_comb begin
        winner_o = OWN_IF;
        gnt_o    = 2'b00;
        // Under contention the side that did not win last time goes next.
        if (req_i == 2'b11) begin
            winner_o = (last_owner_i == OWN_IF) ? OWN_D : OWN_IF;
        end else if (req_i[1]) begin
            winner_o = OWN_D;
        end
        if (enable_i && (|req_i)) begin
            gnt_o = (winner_o == OWN_D) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter and sequencer for a single-ported memory shared by instruction
// fetch (IF) and load/store (D). One access in flight at a time; requesters
// are granted round-robin; read data is returned to the owner with a
// one-cycle valid pulse LAT cycles after the memory strobe.
//   clk, rst           : clock, asynchronous active-low reset
//   if_req/addr/gnt    : fetch request handshake (gnt is a combinational pulse)
//   if_rvalid/rdata    : fetch read response
//   d_req/we/addr/wdata: data request; d_gnt combinational pulse
//   d_rvalid/rdata     : data read response (never for writes)
//   mem_*              : memory strobe, write enable, address, write data, read data
//   busy               : sequencer not idle
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW  = 16,
    parameter int DW  = 16,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    generate
        if (LAT < 1 || LAT > 7) begin : g_lat_range_err
            $error("mem_arbiter: LAT must be in 1..7");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // last_q doubles as the owner of the access in flight: it is updated on
    // every grant, so it always names the requester of the latched command.
    owner_e           last_q, last_d;
    logic             we_q, we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;

    logic             rsp_cycle;
    logic             grant_cap;
    logic [1:0]       gnt;
    owner_e           winner;

    assign rsp_cycle = (state_q == ST_WAIT) && (cnt_q == '0);
    // Grants are suppressed while reset is held so no handshake completes.
    assign grant_cap = rst && ((state_q == ST_IDLE) || rsp_cycle);

    rr_arb2 u_rr (
        .req_i        ({d_req, if_req}),
        .last_owner_i (last_q),
        .enable_i     (grant_cap),
        .gnt_o        (gnt),
        .winner_o     (winner)
    );

    assign if_gnt = gnt[0];
    assign d_gnt  = gnt[1];
    assign busy   = (state_q != ST_IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;

        case (state_q)
            ST_ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (we_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(LAT - 1);
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                    if (last_q == OWN_IF) begin
                        if_rvalid = 1'b1;
                        if_rdata  = mem_rdata;
                    end else begin
                        d_rvalid = 1'b1;
                        d_rdata  = mem_rdata;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A grant overrides the IDLE fall-through of the response cycle.
        if (|gnt) begin
            state_d = ST_ISSUE;
            last_d  = winner;
            if (winner == OWN_D) begin
                we_d    = d_we;
                addr_d  = d_addr;
                wdata_d = d_we ? d_wdata : '0;
            end else begin
                we_d    = 1'b0;
                addr_d  = if_addr;
                wdata_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= OWN_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule
